// File: rtl/collector_pkg.sv
// Shared constants and helpers for the child response collector.
package collector_pkg;

  localparam int unsigned NUM_CHILDREN_DEF = 5;
  localparam int unsigned DATA_W_DEF       = 16;
  localparam int unsigned FIFO_DEPTH_DEF   = 4;
  localparam int unsigned STAT_W           = 16;

  // Width of the child index carried with each buffered entry.
  function automatic int unsigned src_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned entry_w(input int unsigned n, input int unsigned dw);
    return src_w(n) + dw;
  endfunction

  // Round-robin successor of cur, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/collector_fifo.sv
// Synchronous FIFO with registered storage; DEPTH must be a power of two.
module collector_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
    else if (!push_ok && pop_ok) count_d = count_q - CNT_W'(1);
  end

  // Storage is cleared on reset so the head reads zero before the first push.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/child_resp_collector.sv
// Round-robin collector of child response streams into one tagged upstream FIFO.
// Optional COLLECTOR_STATS_EN adds a saturating stat_total accept counter.
module child_resp_collector
  import collector_pkg::*;
#(
  parameter int unsigned NUM_CHILDREN = NUM_CHILDREN_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_CHILDREN-1:0]          child_valid,
  input  logic [NUM_CHILDREN*DATA_W-1:0]   child_data,
  output logic [NUM_CHILDREN-1:0]          child_ready,
  output logic                             up_valid,
  output logic [DATA_W-1:0]                up_data,
  output logic [$clog2(NUM_CHILDREN)-1:0]  up_src,
  input  logic                             up_ready
`ifdef COLLECTOR_STATS_EN
  ,
  output logic [STAT_W-1:0]                stat_total
`endif
);

  localparam int unsigned SRC_W = $clog2(NUM_CHILDREN);
  localparam int unsigned ENT_W = SRC_W + DATA_W;

  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]  gnt_idx;
  logic              gnt_found;
  logic [DATA_W-1:0] gnt_data;
  logic              accept;
  logic              fifo_full, fifo_empty;
  logic [ENT_W-1:0]  fifo_head;

  // Two passes: children at or after rr_ptr first, then the wrapped-around ones.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_data  = '0;
    for (int i = 0; i < int'(NUM_CHILDREN); i++) begin
      if (!gnt_found && child_valid[SRC_W'(i)] && (SRC_W'(i) >= rr_ptr_q)) begin
        gnt_found = 1'b1;
        gnt_idx   = SRC_W'(i);
        gnt_data  = child_data[i*DATA_W +: DATA_W];
      end
    end
    for (int i = 0; i < int'(NUM_CHILDREN); i++) begin
      if (!gnt_found && child_valid[SRC_W'(i)]) begin
        gnt_found = 1'b1;
        gnt_idx   = SRC_W'(i);
        gnt_data  = child_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // A full FIFO accepts nothing, even when the head pops this cycle.
  always_comb begin
    child_ready = '0;
    if (rst_n && gnt_found && !fifo_full) child_ready[gnt_idx] = 1'b1;
  end

  assign accept = |child_ready;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = SRC_W'(rr_next(32'(gnt_idx), NUM_CHILDREN));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

  collector_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data ({gnt_idx, gnt_data}),
    .pop       (up_valid && up_ready),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign up_valid          = !fifo_empty;
  assign {up_src, up_data} = fifo_head;

`ifdef COLLECTOR_STATS_EN
  logic [STAT_W-1:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    if (accept && (stat_q != '1)) stat_d = stat_q + STAT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stat_q <= '0;
    else        stat_q <= stat_d;
  end

  assign stat_total = stat_q;
`endif

endmodule

// File: tb/tb_child_resp_collector.sv
// Directed self-checking bench for child_resp_collector (5 children, 16-bit data, depth 4).
module tb_child_resp_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  child_valid;
  logic [79:0] child_data;
  logic [4:0]  child_ready;
  logic        up_valid;
  logic [15:0] up_data;
  logic [2:0]  up_src;
  logic        up_ready;
`ifdef COLLECTOR_STATS_EN
  logic [15:0] stat_total;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  child_resp_collector dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .child_valid (child_valid),
    .child_data  (child_data),
    .child_ready (child_ready),
    .up_valid    (up_valid),
    .up_data     (up_data),
    .up_src      (up_src),
    .up_ready    (up_ready)
`ifdef COLLECTOR_STATS_EN
    ,
    .stat_total  (stat_total)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    child_valid = 5'b11111;
    up_ready    = 1'b0;
    rst_n       = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cyc();
      tests_run++;
      if (child_ready !== 5'b00000) begin
        tests_failed++;
        $display("FAIL reset_ready cyc%0d got %b exp 00000", k, child_ready);
      end
      tests_run++;
      if (up_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_up_valid cyc%0d got %b exp 0", k, up_valid);
      end
    end
    tests_run++;
    if (up_data !== 16'h0000 || up_src !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_head got data=%h src=%0d exp data=0000 src=0", up_data, up_src);
    end
    child_valid = 5'b00000;
    rst_n       = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_src;
    logic [15:0] exp_data;
    do_reset();
    child_valid = 5'b11111;
    up_ready    = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      exp_src  = 3'(k % 5);
      exp_data = 16'(exp_src) << 4;
      tests_run++;
      if (up_valid !== 1'b1 || up_src !== exp_src || up_data !== exp_data) begin
        tests_failed++;
        $display("FAIL rr_seq step%0d got v=%b src=%0d data=%h exp v=1 src=%0d data=%h",
                 k, up_valid, up_src, up_data, exp_src, exp_data);
      end
    end
    child_valid = 5'b00000;
    repeat (3) cyc();
  endtask

  task automatic test_full();
    do_reset();
    up_ready    = 1'b0;
    child_valid = 5'b00100;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests_run++;
      if (child_ready !== 5'b00100) begin
        tests_failed++;
        $display("FAIL full_fill accept%0d ready got %b exp 00100", k, child_ready);
      end
      cyc();
    end
    #1;
    tests_run++;
    if (child_ready !== 5'b00000 || up_valid !== 1'b1 || up_src !== 3'd2) begin
      tests_failed++;
      $display("FAIL full_stop got ready=%b v=%b src=%0d exp ready=00000 v=1 src=2",
               child_ready, up_valid, up_src);
    end
    up_ready = 1'b1;
    #1;
    tests_run++;
    if (child_ready !== 5'b00000) begin
      tests_failed++;
      $display("FAIL full_no_passthru ready got %b exp 00000", child_ready);
    end
    cyc();
    tests_run++;
    if (child_ready !== 5'b00100 || up_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_after_pop got ready=%b v=%b exp ready=00100 v=1", child_ready, up_valid);
    end
    up_ready = 1'b0;
    cyc();
    tests_run++;
    if (child_ready !== 5'b00000) begin
      tests_failed++;
      $display("FAIL full_refill ready got %b exp 00000", child_ready);
    end
    child_valid = 5'b00000;
    up_ready    = 1'b1;
    repeat (5) cyc();
    tests_run++;
    if (up_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_drain up_valid got %b exp 0", up_valid);
    end
  endtask

  task automatic test_rr_skip();
    do_reset();
    up_ready    = 1'b1;
    child_valid = 5'b00001;
    cyc();
    child_valid = 5'b01000;
    #1;
    tests_run++;
    if (child_ready !== 5'b01000) begin
      tests_failed++;
      $display("FAIL skip_grant3 ready got %b exp 01000", child_ready);
    end
    cyc();
    tests_run++;
    if (up_valid !== 1'b1 || up_src !== 3'd3 || up_data !== 16'h0030) begin
      tests_failed++;
      $display("FAIL skip_head3 got v=%b src=%0d data=%h exp v=1 src=3 data=0030",
               up_valid, up_src, up_data);
    end
    child_valid = 5'b10001;
    #1;
    tests_run++;
    if (child_ready !== 5'b10000) begin
      tests_failed++;
      $display("FAIL skip_grant4 ready got %b exp 10000", child_ready);
    end
    cyc();
    tests_run++;
    if (up_src !== 3'd4 || child_ready !== 5'b00001) begin
      tests_failed++;
      $display("FAIL skip_wrap got src=%0d ready=%b exp src=4 ready=00001", up_src, child_ready);
    end
    child_valid = 5'b00000;
    repeat (3) cyc();
  endtask

  task automatic test_reset_mid();
    do_reset();
    up_ready    = 1'b0;
    child_valid = 5'b00010;
    repeat (3) cyc();
    tests_run++;
    if (up_valid !== 1'b1 || up_src !== 3'd1) begin
      tests_failed++;
      $display("FAIL mid_queued got v=%b src=%0d exp v=1 src=1", up_valid, up_src);
    end
    child_valid = 5'b00000;
    rst_n       = 1'b0;
    cyc();
    tests_run++;
    if (up_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_flush up_valid got %b exp 0", up_valid);
    end
    rst_n       = 1'b1;
    child_valid = 5'b00011;
    #1;
    tests_run++;
    if (child_ready !== 5'b00001) begin
      tests_failed++;
      $display("FAIL mid_rr_ptr ready got %b exp 00001", child_ready);
    end
    cyc();
    child_valid = 5'b00000;
    tests_run++;
    if (up_valid !== 1'b1 || up_src !== 3'd0 || up_data !== 16'h0000) begin
      tests_failed++;
      $display("FAIL mid_new_accept got v=%b src=%0d data=%h exp v=1 src=0 data=0000",
               up_valid, up_src, up_data);
    end
    up_ready = 1'b1;
    cyc();
    tests_run++;
    if (up_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_single_entry up_valid got %b exp 0", up_valid);
    end
  endtask

`ifdef COLLECTOR_STATS_EN
  task automatic test_stats();
    do_reset();
    child_valid = 5'b11111;
    up_ready    = 1'b1;
    repeat (100) cyc();
    tests_run++;
    if (stat_total !== 16'd100) begin
      tests_failed++;
      $display("FAIL stats_count got %0d exp 100", stat_total);
    end
    repeat (69900) cyc();
    tests_run++;
    if (stat_total !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL stats_sat got %h exp ffff", stat_total);
    end
    repeat (10) cyc();
    tests_run++;
    if (stat_total !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL stats_hold got %h exp ffff", stat_total);
    end
    child_valid = 5'b00000;
  endtask
`endif

  initial begin
    rst_n       = 1'b0;
    up_ready    = 1'b0;
    child_valid = 5'b00000;
    for (int i = 0; i < 5; i++) child_data[i*16 +: 16] = 16'(i << 4);
    test_reset();
    test_round_robin();
    test_full();
    test_rr_skip();
    test_reset_mid();
`ifdef COLLECTOR_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
